// File: rtl/decomp_pkg.sv
// decomp_pkg
// Shared types and constants for the decompressor fetch sequencer:
//   - state_t       : sequencer FSM states
//   - TOKEN_LIMIT   : code words below this value are dictionary tokens
//   - INSN_MSB / LEN_LSB / LEN_MSB : field positions inside a dictionary entry
//   - dict_entry_t  : dictionary entry layout {repeat length, instruction}
//   - eff_len()     : repeat length with 0 promoted to 1
//   - is_token()    : code word classification
package decomp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_CODE = 3'd2,
    ST_WAIT_DICT = 3'd3,
    ST_EMIT      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [31:0] TOKEN_LIMIT = 32'h10;

  localparam int INSN_MSB = 31;
  localparam int LEN_LSB  = 32;
  localparam int LEN_MSB  = 35;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [INSN_MSB:0] insn;
  } dict_entry_t;

  // A programmed length of zero still emits the instruction once.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  function automatic logic is_token(input logic [31:0] word);
    return (word < TOKEN_LIMIT);
  endfunction

endpackage

// File: rtl/decomp_emit_reg.sv
// decomp_emit_reg
// Output holding register for the fetch sequencer. Holds the current
// instruction, its uncompressed PC and the number of copies still to emit.
//
// Handshake: o_valid is high while copies remain; a copy is consumed on a
// cycle where o_valid and i_ready are both high. insn/pc do not change while
// o_valid is high and i_ready is low.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load          load i_load_insn with i_load_rep copies (PC unchanged)
//   i_redirect      set PC to i_redirect_pc and drop any pending copies
//   i_ready         consumer accepts the presented copy
//   o_valid/o_insn/o_pc  presented instruction and its PC
//   o_last          the final copy is being accepted this cycle
module decomp_emit_reg
  import decomp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [31:0]      i_load_insn,
  input  logic [LEN_W-1:0] i_load_rep,
  input  logic             i_redirect,
  input  logic [31:0]      i_redirect_pc,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [31:0]      o_insn,
  output logic [31:0]      o_pc,
  output logic             o_last
);

  logic [31:0]      r_insn;
  logic [31:0]      r_pc;
  logic [LEN_W-1:0] r_rep;
  logic             w_fire;

  assign o_valid = (r_rep != '0);
  assign w_fire  = o_valid & i_ready;
  assign o_last  = w_fire & (r_rep == LEN_W'(1));
  assign o_insn  = r_insn;
  assign o_pc    = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_insn <= '0;
      r_pc   <= '0;
      r_rep  <= '0;
    end else if (i_redirect) begin
      r_pc  <= i_redirect_pc;
      r_rep <= '0;
    end else if (i_load) begin
      r_insn <= i_load_insn;
      r_rep  <= i_load_rep;
    end else if (w_fire) begin
      r_pc  <= r_pc + 32'd1;
      r_rep <= r_rep - LEN_W'(1);
    end
  end

endmodule

// File: rtl/decomp_fetch_ctrl.sv
// decomp_fetch_ctrl
// Sequencer between the compressed-code store / token dictionary and the
// pipeline fetch stage. Walks the compressed stream, expands dictionary
// tokens into repeated instructions and tags each with its uncompressed PC.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   run_i                     enable issuing new code reads
//   redirect_i, redirect_caddr_i, redirect_pc_i   branch redirect
//   code_rd_en_o, code_addr_o, code_rdata_i       code store (1-cycle read)
//   dict_rd_en_o, dict_idx_o, dict_rdata_i        dictionary (1-cycle read)
//   insn_valid_o, insn_ready_i, insn_o, pc_o      instruction output
//   done_o                    stream exhausted
//   err_o                     sticky out-of-range token flag
//   raw_cnt_o, tok_cnt_o      saturating word counters (DECOMP_FETCH_STATS_EN)
//   dbg_state_o               current FSM state
//
// Build option: define DECOMP_FETCH_STATS_EN to add raw_cnt_o / tok_cnt_o.
//
// Handshake: insn_o/pc_o are presented while insn_valid_o is high and are
// transferred on any cycle with insn_valid_o && insn_ready_i; they hold while
// insn_ready_i is low, and insn_valid_o only drops after a transfer, a
// redirect or reset.
module decomp_fetch_ctrl
  import decomp_pkg::*;
#(
  parameter int          CODE_AW      = 9,
  parameter int          CODE_DEPTH   = 401,
  parameter int          DICT_DEPTH   = 10,
  parameter int          DICT_AW      = 4,
  parameter logic [31:0] ILLEGAL_INSN = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               redirect_i,
  input  logic [CODE_AW-1:0] redirect_caddr_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               code_rd_en_o,
  output logic [CODE_AW-1:0] code_addr_o,
  input  logic [31:0]        code_rdata_i,
  output logic               dict_rd_en_o,
  output logic [DICT_AW-1:0] dict_idx_o,
  input  logic [35:0]        dict_rdata_i,
  output logic               insn_valid_o,
  input  logic               insn_ready_i,
  output logic [31:0]        insn_o,
  output logic [31:0]        pc_o,
  output logic               done_o,
  output logic               err_o,
`ifdef DECOMP_FETCH_STATS_EN
  output logic [15:0]        raw_cnt_o,
  output logic [15:0]        tok_cnt_o,
`endif
  output logic [2:0]         dbg_state_o
);

  localparam logic [CODE_AW:0] CODE_END = (CODE_AW+1)'(CODE_DEPTH);

  state_t             r_state;
  state_t             w_next;
  logic [CODE_AW-1:0] r_cptr;
  logic               r_err;

  logic               w_code_rd;
  logic               w_dict_rd;
  logic               w_load;
  logic [31:0]        w_load_insn;
  logic [LEN_W-1:0]   w_load_rep;
  logic               w_cptr_inc;
  logic               w_err_set;
  logic               w_at_end;
  logic               w_is_token;
  logic [3:0]         w_tok_idx;
  logic               w_tok_legal;
  logic               w_last;
  dict_entry_t        w_entry;

  assign w_is_token  = is_token(code_rdata_i);
  assign w_tok_idx   = code_rdata_i[3:0];
  assign w_tok_legal = ({28'd0, w_tok_idx} < 32'(DICT_DEPTH));
  assign w_entry     = dict_entry_t'(dict_rdata_i);
  // >= rather than == so a redirect past the end also terminates the stream.
  assign w_at_end    = ({1'b0, r_cptr} >= CODE_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Redirect wins over everything: any read returning this cycle is ignored
  // simply because no state consumes it, and no new read is issued.
  always_comb begin
    w_next      = r_state;
    w_code_rd   = 1'b0;
    w_dict_rd   = 1'b0;
    w_load      = 1'b0;
    w_load_insn = code_rdata_i;
    w_load_rep  = LEN_W'(1);
    w_cptr_inc  = 1'b0;
    w_err_set   = 1'b0;
    if (redirect_i) begin
      w_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_i) w_next = ST_FETCH;
        end
        ST_FETCH: begin
          if (w_at_end) begin
            w_next = ST_DONE;
          end else begin
            w_code_rd = 1'b1;
            w_next    = ST_WAIT_CODE;
          end
        end
        ST_WAIT_CODE: begin
          w_cptr_inc = 1'b1;
          if (!w_is_token) begin
            w_load = 1'b1;
            w_next = ST_EMIT;
          end else if (w_tok_legal) begin
            w_dict_rd = 1'b1;
            w_next    = ST_WAIT_DICT;
          end else begin
            w_load      = 1'b1;
            w_load_insn = ILLEGAL_INSN;
            w_err_set   = 1'b1;
            w_next      = ST_EMIT;
          end
        end
        ST_WAIT_DICT: begin
          w_load      = 1'b1;
          w_load_insn = w_entry.insn;
          w_load_rep  = eff_len(w_entry.len);
          w_next      = ST_EMIT;
        end
        ST_EMIT: begin
          // Next code read overlaps the final accepting handshake.
          if (w_last) begin
            if (w_at_end) begin
              w_next = ST_DONE;
            end else if (run_i) begin
              w_code_rd = 1'b1;
              w_next    = ST_WAIT_CODE;
            end else begin
              w_next = ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          w_next = ST_DONE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cptr <= '0;
    else if (redirect_i) r_cptr <= redirect_caddr_i;
    else if (w_cptr_inc) r_cptr <= r_cptr + CODE_AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  decomp_emit_reg u_emit (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_load_insn   (w_load_insn),
    .i_load_rep    (w_load_rep),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .i_ready       (insn_ready_i),
    .o_valid       (insn_valid_o),
    .o_insn        (insn_o),
    .o_pc          (pc_o),
    .o_last        (w_last)
  );

  assign code_rd_en_o = w_code_rd;
  assign code_addr_o  = r_cptr;
  assign dict_rd_en_o = w_dict_rd;
  assign dict_idx_o   = DICT_AW'(w_tok_idx);
  assign done_o       = (r_state == ST_DONE);
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

`ifdef DECOMP_FETCH_STATS_EN
  logic [15:0] r_raw_cnt;
  logic [15:0] r_tok_cnt;
  logic        w_consume;

  // A word counts as consumed only when it is actually classified.
  assign w_consume = (r_state == ST_WAIT_CODE) && !redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw_cnt <= '0;
      r_tok_cnt <= '0;
    end else if (w_consume) begin
      if (!w_is_token && (r_raw_cnt != 16'hFFFF)) r_raw_cnt <= r_raw_cnt + 16'd1;
      if (w_is_token && (r_tok_cnt != 16'hFFFF))  r_tok_cnt <= r_tok_cnt + 16'd1;
    end
  end

  assign raw_cnt_o = r_raw_cnt;
  assign tok_cnt_o = r_tok_cnt;
`endif

endmodule
